// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between N byte requesters, the shared uart_tx byte channel
// and the arbiter that owns it.
//   req_data         8*N  byte of requester k at [8k+7:8k]
//   req_vld          N    byte valid per requester
//   req_last         N    byte is last of its packet (qualified by req_vld)
//   req_rdy          N    byte accepted from requester k
//   uart_tx_data     8    byte to uart_tx
//   uart_tx_data_vld 1    byte valid to uart_tx
//   uart_tx_data_rdy 1    uart_tx ready for a byte
//   gnt              N    one-hot current owner, 0 when idle
//   busy             1    channel locked to an owner
//   timeout          1    one-cycle pulse on watchdog release
// master: requesters plus uart_tx side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_rdy;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_data_vld;
  logic           uart_tx_data_rdy;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           timeout;

  modport master (
    output req_data, req_vld, req_last, uart_tx_data_rdy,
    input  req_rdy, uart_tx_data, uart_tx_data_vld, gnt, busy, timeout
  );

  modport slave (
    input  req_data, req_vld, req_last, uart_tx_data_rdy,
    output req_rdy, uart_tx_data, uart_tx_data_vld, gnt, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte channel among
// N requesters. The grant is held until the owner's last byte is accepted, so
// packets never interleave; a stall watchdog releases a dead owner.
// Ports:
//   clk_i  clock
//   rst_i  synchronous reset, active-high
//   bus    uart_tx_arbiter_if.slave (requester bytes, uart_tx channel, status)
// Parameters: N requesters (2..8), TIMEOUT owner-idle cycles before forced
// release (0 disables the watchdog).
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input logic               clk_i,
  input logic               rst_i,
  uart_tx_arbiter_if.slave  bus
);
  localparam int PW = $clog2(N);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [WW-1:0]   wdog, wdog_nxt;
  logic [N-1:0]    gnt;
  logic            busy;

  logic            own_vld, own_last;
  logic [7:0]      own_data;
  logic [PW-1:0]   owner_inc;
  logic            xfer, stall_fire;

  logic [2*N-1:0]  vld_dbl;
  logic [N-1:0]    vld_rot;
  logic [PW-1:0]   off;
  logic [PW:0]     pick_sum;
  logic [PW-1:0]   pick;

  // Owner's request lines.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int k = 0; k < N; k++) begin
      if (owner == PW'(k)) begin
        own_vld  = bus.req_vld[k];
        own_last = bus.req_last[k];
        own_data = bus.req_data[8*k +: 8];
      end
    end
  end

  // Round-robin pick: rotate vld so bit 0 is the requester at ptr, take the
  // lowest set bit, then rotate the offset back.
  always_comb begin
    vld_dbl = {bus.req_vld, bus.req_vld} >> ptr;
    vld_rot = vld_dbl[N-1:0];
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vld_rot[i]) off = PW'(i);
    end
    pick_sum = {1'b0, ptr} + {1'b0, off};
    pick     = (pick_sum >= (PW+1)'(N)) ? PW'(pick_sum - (PW+1)'(N)) : PW'(pick_sum);
  end

  assign owner_inc  = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
  assign xfer       = (state == LOCK) && own_vld && bus.uart_tx_data_rdy;
  // Only an owner that withdrew vld counts as stalled; backpressure does not.
  assign stall_fire = (TIMEOUT != 0) && (state == LOCK) && !own_vld && (wdog == WD_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      wdog  <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      wdog  <= wdog_nxt;
      gnt   <= (state_nxt == LOCK) ? (N'(1) << owner_nxt) : '0;
      busy  <= (state_nxt == LOCK);
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    wdog_nxt  = wdog;
    case (state)
      IDLE: begin
        wdog_nxt = '0;
        if (|bus.req_vld) begin
          state_nxt = LOCK;
          owner_nxt = pick;
        end
      end
      LOCK: begin
        if (xfer) begin
          wdog_nxt = '0;
          if (own_last) begin
            state_nxt = IDLE;
            ptr_nxt   = owner_inc;
          end
        end else if (stall_fire) begin
          state_nxt = IDLE;
          ptr_nxt   = owner_inc;
          wdog_nxt  = '0;
        end else if (!own_vld && (TIMEOUT != 0)) begin
          wdog_nxt = wdog + WW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the channel is a straight pass-through from the owner.
  always_comb begin
    bus.uart_tx_data     = '0;
    bus.uart_tx_data_vld = 1'b0;
    bus.req_rdy          = '0;
    bus.timeout          = 1'b0;
    if (state == LOCK) begin
      bus.uart_tx_data     = own_data;
      bus.uart_tx_data_vld = own_vld;
      bus.req_rdy          = xfer ? (N'(1) << owner) : '0;
      bus.timeout          = stall_fire;
    end
  end

  assign bus.gnt  = gnt;
  assign bus.busy = busy;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.gnt));
  a_rdy_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.req_rdy));
  a_vld_busy:   assert property (@(posedge clk_i) disable iff (rst_i) !bus.busy |-> !bus.uart_tx_data_vld);
endmodule
